// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: memory read channel, decode handoff and status.
interface ifu_fetch_if;
    localparam int unsigned XLEN = 32;

    // Memory read-address / read-data channel
    logic [XLEN-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    // Decode handoff and next-PC return
    logic            ifu_send_valid;
    logic            idu_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            pc_write_enable;

    // Status
    logic            fetch_fault;
    logic [XLEN-1:0] fetch_count;

    // Fetch unit side
    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output ifu_send_valid, instruction, pc,
        input  idu_ready, pc_next, pc_write_enable,
        output fetch_fault, fetch_count
    );

    // Memory / decode side
    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  ifu_send_valid, instruction, pc,
        output idu_ready, pc_next, pc_write_enable,
        input  fetch_fault, fetch_count
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one fetch in flight, hands {instruction, pc} to decode,
// then waits for decode to supply the next PC. Halts sticky on any access fault.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_SEND,
        S_WAIT_PC,
        S_FAULT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_araddr;
    logic            r_arvalid;
    logic            r_rready;
    logic            r_send_valid;
    logic [XLEN-1:0] r_instruction;
    logic            r_fetch_fault;
    logic [XLEN-1:0] r_fetch_count;

    state_t          w_state;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_araddr;
    logic            w_arvalid;
    logic            w_rready;
    logic            w_send_valid;
    logic [XLEN-1:0] w_instruction;
    logic            w_fetch_fault;
    logic [XLEN-1:0] w_fetch_count;

    // Next-state and next-output decode; every register holds unless a handshake moves it.
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_araddr      = r_araddr;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_send_valid  = r_send_valid;
        w_instruction = r_instruction;
        w_fetch_fault = r_fetch_fault;
        w_fetch_count = r_fetch_count;

        case (r_state)
            S_IDLE: begin
                w_arvalid = 1'b1;
                w_araddr  = r_pc;
                w_state   = S_AR;
            end

            S_AR: begin
                if (r_arvalid && bus.arready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = S_R;
                end
            end

            S_R: begin
                if (bus.rvalid && r_rready) begin
                    w_rready = 1'b0;
                    if (bus.rresp == 2'b00) begin
                        w_instruction = bus.rdata;
                        w_send_valid  = 1'b1;
                        w_state       = S_SEND;
                    end else begin
                        w_fetch_fault = 1'b1;
                        w_state       = S_FAULT;
                    end
                end
            end

            S_SEND: begin
                if (r_send_valid && bus.idu_ready) begin
                    w_send_valid  = 1'b0;
                    w_fetch_count = r_fetch_count + XLEN'(1);
                    w_state       = S_WAIT_PC;
                end
            end

            S_WAIT_PC: begin
                if (bus.pc_write_enable) begin
                    if (bus.pc_next[1:0] == 2'b00) begin
                        w_pc      = bus.pc_next;
                        w_araddr  = bus.pc_next;
                        w_arvalid = 1'b1;
                        w_state   = S_AR;
                    end else begin
                        // Misaligned target: halt without touching the PC
                        w_fetch_fault = 1'b1;
                        w_state       = S_FAULT;
                    end
                end
            end

            S_FAULT: begin
                w_arvalid    = 1'b0;
                w_rready     = 1'b0;
                w_send_valid = 1'b0;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_araddr      <= RESET_PC;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_send_valid  <= 1'b0;
            r_instruction <= '0;
            r_fetch_fault <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_araddr      <= w_araddr;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_send_valid  <= w_send_valid;
            r_instruction <= w_instruction;
            r_fetch_fault <= w_fetch_fault;
            r_fetch_count <= w_fetch_count;
        end
    end

    assign bus.araddr         = r_araddr;
    assign bus.arvalid        = r_arvalid;
    assign bus.rready         = r_rready;
    assign bus.ifu_send_valid = r_send_valid;
    assign bus.instruction    = r_instruction;
    assign bus.pc             = r_pc;
    assign bus.fetch_fault    = r_fetch_fault;
    assign bus.fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: the bench plays memory and decode, and a
// transaction-level model (PC, memory contents, accepted count) gives expectations.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] model_pc;
    logic [31:0] model_count;

    // Memory image: any fixed scramble of the address serves as a distinct word per PC
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arready         = 1'b0;
        bus.rvalid          = 1'b0;
        bus.rresp           = 2'b00;
        bus.rdata           = '0;
        bus.idu_ready       = 1'b0;
        bus.pc_write_enable = 1'b0;
        bus.pc_next         = '0;
    endtask

    // Holds rst high for some cycles; model returns to its reset view
    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        repeat (cycles) step();
        model_pc    = RESET_PC;
        model_count = '0;
    endtask

    // Plays memory then decode for one fetch; reports what was seen and whether
    // outputs stayed stable / single-handshake throughout.
    task automatic do_fetch(input int ar_dly, input int r_dly, input logic [31:0] word,
                            input logic [1:0] resp, input int idu_dly, input bit pulse_pc,
                            output logic [31:0] got_addr, output logic got_send,
                            output logic [31:0] got_instr, output logic [31:0] got_pc,
                            output bit proto_ok, output logic [31:0] cnt_before);
        proto_ok   = 1'b1;
        got_addr   = bus.araddr;
        got_send   = 1'b0;
        got_instr  = '0;
        got_pc     = '0;
        cnt_before = bus.fetch_count;
        if (bus.arvalid !== 1'b1) proto_ok = 1'b0;
        for (int i = 0; i < ar_dly; i++) begin
            bus.arready = 1'b0;
            step();
            if (bus.arvalid !== 1'b1 || bus.araddr !== got_addr || bus.rready !== 1'b0) proto_ok = 1'b0;
        end
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        if (bus.arvalid !== 1'b0 || bus.rready !== 1'b1) proto_ok = 1'b0;
        for (int i = 0; i < r_dly; i++) begin
            bus.rvalid = 1'b0;
            bus.rdata  = $urandom;
            step();
            if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0 || bus.ifu_send_valid !== 1'b0) proto_ok = 1'b0;
        end
        bus.rvalid = 1'b1;
        bus.rdata  = word;
        bus.rresp  = resp;
        step();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        bus.rdata  = $urandom;
        if (bus.rready !== 1'b0 || bus.arvalid !== 1'b0) proto_ok = 1'b0;
        got_send  = bus.ifu_send_valid;
        got_instr = bus.instruction;
        got_pc    = bus.pc;
        if (got_send !== 1'b1) return;
        for (int i = 0; i < idu_dly; i++) begin
            bus.idu_ready = 1'b0;
            if (pulse_pc && i == 0) begin
                bus.pc_write_enable = 1'b1;
                bus.pc_next         = $urandom & ~32'd3;
            end
            step();
            bus.pc_write_enable = 1'b0;
            if (bus.ifu_send_valid !== 1'b1 || bus.instruction !== got_instr || bus.pc !== got_pc ||
                bus.fetch_count !== cnt_before || bus.arvalid !== 1'b0) proto_ok = 1'b0;
        end
        bus.idu_ready = 1'b1;
        step();
        bus.idu_ready = 1'b0;
        if (bus.ifu_send_valid !== 1'b0 || bus.arvalid !== 1'b0) proto_ok = 1'b0;
    endtask

    // Decode returns the next PC after some idle cycles in WAIT_PC
    task automatic give_pc(input logic [31:0] v, input int wait_cycles, output bit quiet_ok);
        quiet_ok = 1'b1;
        for (int i = 0; i < wait_cycles; i++) begin
            step();
            if (bus.arvalid !== 1'b0 || bus.ifu_send_valid !== 1'b0) quiet_ok = 1'b0;
        end
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = v;
        step();
        bus.pc_write_enable = 1'b0;
        bus.pc_next         = $urandom;
        if (v[1:0] == 2'b00) model_pc = v;
    endtask

    logic [31:0] g_addr, g_instr, g_pc, g_cnt;
    logic        g_send;
    bit          g_ok, g_quiet;

    task automatic test_reset();
        hold_reset(3);
        vectors++; if (bus.arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %b expected 0", bus.arvalid); end
        vectors++; if (bus.araddr !== RESET_PC) begin miscompares++; $display("FAIL reset_araddr: got %h expected %h", bus.araddr, RESET_PC); end
        vectors++; if (bus.pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", bus.pc, RESET_PC); end
        vectors++; if ({bus.rready, bus.ifu_send_valid, bus.fetch_fault} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {bus.rready, bus.ifu_send_valid, bus.fetch_fault}); end
        vectors++; if (bus.instruction !== 32'h0 || bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_instr_count: got %h/%h expected 0/0", bus.instruction, bus.fetch_count); end
        bus.arready = 1'b1;
        rst = 1'b0;
        step();
        vectors++; if (bus.arvalid !== 1'b1 || bus.araddr !== RESET_PC) begin miscompares++; $display("FAIL first_fetch_addr: got %b/%h expected 1/%h", bus.arvalid, bus.araddr, RESET_PC); end
        do_fetch(0, 0, 32'h0000_0013, 2'b00, 0, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        model_count++;
        vectors++; if (g_send !== 1'b1) begin miscompares++; $display("FAIL first_send_latency: got %b expected 1", g_send); end
        vectors++; if (g_instr !== 32'h0000_0013 || g_pc !== RESET_PC) begin miscompares++; $display("FAIL first_send_data: got %h@%h expected 00000013@%h", g_instr, g_pc, RESET_PC); end
        vectors++; if (g_ok !== 1'b1) begin miscompares++; $display("FAIL first_protocol: got %b expected 1", g_ok); end
        vectors++; if (bus.fetch_count !== model_count) begin miscompares++; $display("FAIL first_count: got %0d expected %0d", bus.fetch_count, model_count); end
    endtask

    task automatic test_idu_stall();
        give_pc(model_pc + 32'd4, 0, g_quiet);
        vectors++; if (bus.arvalid !== 1'b1 || bus.araddr !== model_pc) begin miscompares++; $display("FAIL stall_addr: got %b/%h expected 1/%h", bus.arvalid, bus.araddr, model_pc); end
        do_fetch(0, 0, mem_word(model_pc), 2'b00, 5, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        vectors++; if (g_ok !== 1'b1) begin miscompares++; $display("FAIL stall_stable: got %b expected 1", g_ok); end
        vectors++; if (g_cnt !== model_count) begin miscompares++; $display("FAIL stall_count_before: got %0d expected %0d", g_cnt, model_count); end
        model_count++;
        vectors++; if (bus.fetch_count !== model_count) begin miscompares++; $display("FAIL stall_count_after: got %0d expected %0d", bus.fetch_count, model_count); end
        vectors++; if (g_instr !== mem_word(model_pc) || g_pc !== model_pc) begin miscompares++; $display("FAIL stall_data: got %h@%h expected %h@%h", g_instr, g_pc, mem_word(model_pc), model_pc); end
    endtask

    task automatic test_pc_redirect();
        give_pc(32'h8000_0040, 2, g_quiet);
        vectors++; if (g_quiet !== 1'b1) begin miscompares++; $display("FAIL redirect_quiet: got %b expected 1", g_quiet); end
        vectors++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0040) begin miscompares++; $display("FAIL redirect_addr: got %b/%h expected 1/80000040", bus.arvalid, bus.araddr); end
        do_fetch(1, 1, mem_word(model_pc), 2'b00, 1, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        model_count++;
        vectors++; if (g_pc !== 32'h8000_0040 || g_instr !== mem_word(32'h8000_0040)) begin miscompares++; $display("FAIL redirect_send: got %h@%h expected %h@80000040", g_instr, g_pc, mem_word(32'h8000_0040)); end
    endtask

    task automatic test_slow_memory();
        give_pc(32'h8000_0044, 0, g_quiet);
        do_fetch(3, 4, mem_word(model_pc), 2'b00, 0, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        model_count++;
        vectors++; if (g_ok !== 1'b1) begin miscompares++; $display("FAIL slow_protocol: got %b expected 1", g_ok); end
        vectors++; if (g_addr !== 32'h8000_0044) begin miscompares++; $display("FAIL slow_addr: got %h expected 80000044", g_addr); end
        vectors++; if (g_send !== 1'b1 || g_instr !== mem_word(32'h8000_0044)) begin miscompares++; $display("FAIL slow_word: got %b/%h expected 1/%h", g_send, g_instr, mem_word(32'h8000_0044)); end
    endtask

    task automatic test_pc_write_in_send();
        give_pc(32'h8000_0100, 1, g_quiet);
        do_fetch(0, 0, mem_word(model_pc), 2'b00, 3, 1'b1, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        model_count++;
        vectors++; if (g_ok !== 1'b1) begin miscompares++; $display("FAIL send_pulse_ignored: got %b expected 1", g_ok); end
        vectors++; if (bus.pc !== 32'h8000_0100 || bus.fetch_count !== model_count) begin miscompares++; $display("FAIL send_pulse_state: got %h/%0d expected 80000100/%0d", bus.pc, bus.fetch_count, model_count); end
    endtask

    task automatic test_random();
        logic [31:0] nxt;
        for (int n = 0; n < 24; n++) begin
            nxt = RESET_PC + ($urandom_range(0, 1023) << 2);
            give_pc(nxt, $urandom_range(0, 3), g_quiet);
            vectors++; if (bus.arvalid !== 1'b1 || bus.araddr !== nxt || g_quiet !== 1'b1) begin miscompares++; $display("FAIL rand_addr[%0d]: got %b/%h expected 1/%h", n, bus.arvalid, bus.araddr, nxt); end
            do_fetch($urandom_range(0, 4), $urandom_range(0, 4), mem_word(model_pc), 2'b00,
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)), g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
            model_count++;
            vectors++; if (g_send !== 1'b1 || g_pc !== model_pc || g_instr !== mem_word(model_pc)) begin miscompares++; $display("FAIL rand_send[%0d]: got %b %h@%h expected 1 %h@%h", n, g_send, g_instr, g_pc, mem_word(model_pc), model_pc); end
            vectors++; if (g_ok !== 1'b1 || bus.fetch_count !== model_count) begin miscompares++; $display("FAIL rand_proto_count[%0d]: got %b/%0d expected 1/%0d", n, g_ok, bus.fetch_count, model_count); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] pc_before;
        pc_before = model_pc;
        give_pc(32'h8000_0042, 0, g_quiet);
        vectors++; if (bus.fetch_fault !== 1'b1 || bus.arvalid !== 1'b0) begin miscompares++; $display("FAIL misalign_fault: got %b/%b expected 1/0", bus.fetch_fault, bus.arvalid); end
        vectors++; if (bus.pc !== pc_before || bus.fetch_count !== model_count) begin miscompares++; $display("FAIL misalign_hold: got %h/%0d expected %h/%0d", bus.pc, bus.fetch_count, pc_before, model_count); end
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.idu_ready = 1'b1;
        bus.pc_write_enable = 1'b1; bus.pc_next = 32'h8000_0080;
        repeat (4) step();
        vectors++; if ({bus.arvalid, bus.rready, bus.ifu_send_valid, bus.fetch_fault} !== 4'b0001 || bus.pc !== pc_before) begin miscompares++; $display("FAIL misalign_halted: got %b/%h expected 0001/%h", {bus.arvalid, bus.rready, bus.ifu_send_valid, bus.fetch_fault}, bus.pc, pc_before); end
    endtask

    task automatic test_resp_fault();
        hold_reset(2);
        vectors++; if (bus.fetch_fault !== 1'b0 || bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL fault_cleared_by_reset: got %b/%0d expected 0/0", bus.fetch_fault, bus.fetch_count); end
        rst = 1'b0;
        step();
        do_fetch(0, 1, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        vectors++; if (g_send !== 1'b0 || bus.fetch_fault !== 1'b1) begin miscompares++; $display("FAIL rresp_fault: got send=%b fault=%b expected 0/1", g_send, bus.fetch_fault); end
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.idu_ready = 1'b1;
        bus.pc_write_enable = 1'b1; bus.pc_next = 32'h8000_0008;
        repeat (5) step();
        idle_inputs();
        vectors++; if ({bus.arvalid, bus.rready, bus.ifu_send_valid, bus.fetch_fault} !== 4'b0001 || bus.fetch_count !== 32'h0) begin miscompares++; $display("FAIL rresp_halted: got %b/%0d expected 0001/0", {bus.arvalid, bus.rready, bus.ifu_send_valid, bus.fetch_fault}, bus.fetch_count); end
        hold_reset(1);
        rst = 1'b0;
        step();
        vectors++; if (bus.fetch_fault !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== RESET_PC) begin miscompares++; $display("FAIL refetch_after_fault: got %b/%b/%h expected 0/1/%h", bus.fetch_fault, bus.arvalid, bus.araddr, RESET_PC); end
    endtask

    task automatic test_reset_mid_read();
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        vectors++; if (bus.rready !== 1'b1) begin miscompares++; $display("FAIL midread_setup: got %b expected 1", bus.rready); end
        rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
        step();
        model_pc = RESET_PC; model_count = '0;
        vectors++; if ({bus.arvalid, bus.rready, bus.ifu_send_valid} !== 3'b000 || bus.instruction !== 32'h0) begin miscompares++; $display("FAIL midread_reset: got %b/%h expected 000/0", {bus.arvalid, bus.rready, bus.ifu_send_valid}, bus.instruction); end
        rst = 1'b0; bus.rvalid = 1'b0;
        step();
        vectors++; if (bus.arvalid !== 1'b1 || bus.araddr !== RESET_PC) begin miscompares++; $display("FAIL midread_refetch: got %b/%h expected 1/%h", bus.arvalid, bus.araddr, RESET_PC); end
        do_fetch(2, 2, mem_word(RESET_PC), 2'b00, 1, 1'b0, g_addr, g_send, g_instr, g_pc, g_ok, g_cnt);
        model_count++;
        vectors++; if (g_instr !== mem_word(RESET_PC) || bus.fetch_count !== model_count) begin miscompares++; $display("FAIL midread_fetch: got %h/%0d expected %h/%0d", g_instr, bus.fetch_count, mem_word(RESET_PC), model_count); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_idu_stall();
        test_pc_redirect();
        test_slow_memory();
        test_pc_write_in_send();
        test_random();
        test_misaligned();
        test_resp_fault();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
